// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter that turns IFU line-fill and LSU single-beat requests into
// AXI4 master transactions, one transaction in flight at a time.
module axi_mem_arbiter #(
   parameter int unsigned IFU_BURST_LEN = 4,
   parameter logic [3:0]  IFU_ID        = 4'd0,
   parameter logic [3:0]  LSU_ID        = 4'd1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_req_addr,
   output logic [63:0] ifu_rdata,
   output logic        ifu_rvalid,
   output logic        ifu_rlast,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic        lsu_req_wen,
   input  logic [31:0] lsu_req_addr,
   input  logic [63:0] lsu_req_wdata,
   input  logic [7:0]  lsu_req_wstrb,
   output logic [63:0] lsu_rdata,
   output logic        lsu_resp_valid,
   output logic [31:0] m_araddr,
   output logic [3:0]  m_arid,
   output logic [7:0]  m_arlen,
   output logic [2:0]  m_arsize,
   output logic [1:0]  m_arburst,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [3:0]  m_rid,
   input  logic [63:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rlast,
   input  logic        m_rvalid,
   output logic        m_rready,
   output logic [31:0] m_awaddr,
   output logic [3:0]  m_awid,
   output logic [7:0]  m_awlen,
   output logic [2:0]  m_awsize,
   output logic [1:0]  m_awburst,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [63:0] m_wdata,
   output logic [7:0]  m_wstrb,
   output logic        m_wlast,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic [3:0]  m_bid,
   input  logic [1:0]  m_bresp,
   input  logic        m_bvalid,
   output logic        m_bready
);

   typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWrReq, StWrResp} state_e;

   localparam logic [31:0] LineMask = ~(32'(IFU_BURST_LEN * 8) - 32'd1);
   localparam logic [7:0]  IfuLen   = 8'(IFU_BURST_LEN - 1);

   state_e      state_q, state_d;
   logic        last_lsu_q, last_lsu_d;
   logic        sel_lsu_q, sel_lsu_d;
   logic [31:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [7:0]  wstrb_q, wstrb_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        grant_ifu, grant_lsu;
   logic [3:0]  gnt_id;
   logic        unused_inputs;

   assign gnt_id        = sel_lsu_q ? LSU_ID : IFU_ID;
   assign unused_inputs = ^{m_rresp, m_bid, m_bresp};

   // Grants are gated by reset so no ready pulse appears without a latch.
   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (state_q == StIdle && aresetn) begin
         if (ifu_req_valid && lsu_req_valid) begin
            grant_ifu = last_lsu_q;
            grant_lsu = !last_lsu_q;
         end else begin
            grant_ifu = ifu_req_valid;
            grant_lsu = lsu_req_valid;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      last_lsu_d     = last_lsu_q;
      sel_lsu_d      = sel_lsu_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      wstrb_d        = wstrb_q;
      aw_done_d      = aw_done_q;
      w_done_d       = w_done_q;
      ifu_req_ready  = grant_ifu;
      lsu_req_ready  = grant_lsu;
      ifu_rdata      = 64'd0;
      ifu_rvalid     = 1'b0;
      ifu_rlast      = 1'b0;
      lsu_rdata      = 64'd0;
      lsu_resp_valid = 1'b0;
      m_araddr       = 32'd0;
      m_arid         = 4'd0;
      m_arlen        = 8'd0;
      m_arsize       = 3'd0;
      m_arburst      = 2'b00;
      m_arvalid      = 1'b0;
      m_rready       = 1'b0;
      m_awaddr       = 32'd0;
      m_awid         = 4'd0;
      m_awlen        = 8'd0;
      m_awsize       = 3'd0;
      m_awburst      = 2'b00;
      m_awvalid      = 1'b0;
      m_wdata        = 64'd0;
      m_wstrb        = 8'd0;
      m_wlast        = 1'b0;
      m_wvalid       = 1'b0;
      m_bready       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant_ifu || grant_lsu) begin
               sel_lsu_d = grant_lsu;
               addr_d    = grant_lsu ? lsu_req_addr : ifu_req_addr;
               wdata_d   = lsu_req_wdata;
               wstrb_d   = lsu_req_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = (grant_lsu && lsu_req_wen) ? StWrReq : StRdAddr;
            end
         end
         StRdAddr: begin
            m_arvalid = 1'b1;
            m_araddr  = sel_lsu_q ? addr_q : (addr_q & LineMask);
            m_arlen   = sel_lsu_q ? 8'd0 : IfuLen;
            m_arid    = gnt_id;
            m_arsize  = 3'd3;
            m_arburst = 2'b01;
            if (m_arready) state_d = StRdData;
         end
         StRdData: begin
            m_rready = 1'b1;
            // Beats carrying another id are accepted and discarded.
            if (m_rvalid && m_rid == gnt_id) begin
               if (sel_lsu_q) begin
                  lsu_resp_valid = 1'b1;
                  lsu_rdata      = m_rdata;
               end else begin
                  ifu_rvalid = 1'b1;
                  ifu_rdata  = m_rdata;
                  ifu_rlast  = m_rlast;
               end
               if (m_rlast) begin
                  state_d    = StIdle;
                  last_lsu_d = sel_lsu_q;
               end
            end
         end
         StWrReq: begin
            m_awvalid = !aw_done_q;
            m_awaddr  = addr_q;
            m_awid    = LSU_ID;
            m_awsize  = 3'd3;
            m_awburst = 2'b01;
            m_wvalid  = !w_done_q;
            m_wdata   = wdata_q;
            m_wstrb   = wstrb_q;
            m_wlast   = 1'b1;
            aw_done_d = aw_done_q | (m_awvalid & m_awready);
            w_done_d  = w_done_q | (m_wvalid & m_wready);
            if (aw_done_d && w_done_d) state_d = StWrResp;
         end
         StWrResp: begin
            m_bready = 1'b1;
            if (m_bvalid) begin
               lsu_resp_valid = 1'b1;
               state_d        = StIdle;
               last_lsu_d     = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q    <= StIdle;
         last_lsu_q <= 1'b1;
         sel_lsu_q  <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 64'd0;
         wstrb_q    <= 8'd0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_lsu_q <= last_lsu_d;
         sel_lsu_q  <= sel_lsu_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
      end
   end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: a behavioural AXI slave with scoreboard queues for
// AR/AW/W traffic and IFU/LSU responses, driven by directed request vectors.
module tb_axi_mem_arbiter;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        ifu_req_valid, ifu_req_ready, ifu_rvalid, ifu_rlast;
   logic [31:0] ifu_req_addr;
   logic [63:0] ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
   logic [31:0] lsu_req_addr;
   logic [63:0] lsu_req_wdata, lsu_rdata;
   logic [7:0]  lsu_req_wstrb;
   logic [31:0] m_araddr, m_awaddr;
   logic [3:0]  m_arid, m_awid, m_rid, m_bid;
   logic [7:0]  m_arlen, m_awlen, m_wstrb;
   logic [2:0]  m_arsize, m_awsize;
   logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
   logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
   logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [63:0] m_rdata, m_wdata;

   axi_mem_arbiter #(.IFU_BURST_LEN(4), .IFU_ID(4'd0), .LSU_ID(4'd1)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_req_addr(ifu_req_addr), .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
      .ifu_rlast(ifu_rlast),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
      .lsu_rdata(lsu_rdata), .lsu_resp_valid(lsu_resp_valid),
      .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
      .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   logic [43:0] ar_exp_q[$];   // {addr, len, id}
   logic [31:0] aw_exp_q[$];
   logic [71:0] w_exp_q[$];    // {data, strb}
   logic [64:0] ifu_exp_q[$];  // {last, data}
   logic [64:0] lsu_exp_q[$];  // {is_write, data}
   int          lsu_times[$];
   logic [63:0] mem [logic [31:0]];

   int  ar_delay = 0, ar_cnt = 0, aw_delay = 0, aw_cnt = 0;
   bit  stray_pend = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] pat(input logic [31:0] a);
      return {a, a ^ 32'hA5A5_A5A5};
   endfunction

   function automatic logic [63:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return pat(a);
   endfunction

   // Behavioural slave: drives at negedge, resolves handshakes 1 time unit later.
   initial begin
      logic [31:0] r_addr_q[$];
      logic [7:0]  r_len_q[$];
      logic [3:0]  r_id_q[$];
      int          r_beat;
      bit          stray_on, aw_got, w_got, b_pend;
      logic [31:0] aw_addr;
      logic [63:0] w_data, cur;
      logic [7:0]  w_strb;
      logic [43:0] ea;
      logic [71:0] ew;
      r_beat = 0; aw_got = 0; w_got = 0; b_pend = 0;
      m_arready = 0; m_rvalid = 0; m_rid = 0; m_rdata = 0; m_rlast = 0; m_rresp = 0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bid = 0; m_bresp = 0;
      forever begin
         @(negedge aclk);
         m_arready = (ar_cnt >= ar_delay);
         m_awready = (aw_cnt >= aw_delay);
         m_wready  = 1'b1;
         stray_on  = 0;
         if (r_addr_q.size() > 0 && stray_pend && r_beat == 1) begin
            stray_on = 1;
            m_rvalid = 1; m_rid = 4'd1; m_rdata = 64'hBAD0_BAD0_BAD0_BAD0; m_rlast = 0;
         end else if (r_addr_q.size() > 0) begin
            m_rvalid = 1; m_rid = r_id_q[0];
            m_rdata  = rd(r_addr_q[0] + 32'(8 * r_beat));
            m_rlast  = (r_beat == int'(r_len_q[0]));
         end else begin
            m_rvalid = 0; m_rid = 0; m_rdata = 0; m_rlast = 0;
         end
         m_bvalid = b_pend; m_bid = 4'd1;
         #1;
         if (m_arvalid) begin
            if (m_arready) begin
               if (ar_exp_q.size() == 0) check("ar_unexpected", 1, 0);
               else begin
                  ea = ar_exp_q.pop_front();
                  check("ar_addr_len_id", {m_araddr, m_arlen, m_arid}, ea);
                  check("ar_size_burst", {m_arsize, m_arburst}, {3'd3, 2'b01});
               end
               r_addr_q.push_back(m_araddr); r_len_q.push_back(m_arlen);
               r_id_q.push_back(m_arid);
               ar_cnt = 0;
            end else ar_cnt++;
         end
         if (m_rvalid && m_rready) begin
            if (stray_on) stray_pend = 0;
            else if (m_rlast) begin
               void'(r_addr_q.pop_front()); void'(r_len_q.pop_front());
               void'(r_id_q.pop_front()); r_beat = 0;
            end else r_beat++;
         end
         if (m_bvalid && m_bready) b_pend = 0;
         if (m_awvalid) begin
            if (m_awready) begin
               if (aw_exp_q.size() == 0) check("aw_unexpected", 1, 0);
               else check("aw_addr", m_awaddr, aw_exp_q.pop_front());
               check("aw_len_size_burst_id", {m_awlen, m_awsize, m_awburst, m_awid},
                     {8'd0, 3'd3, 2'b01, 4'd1});
               aw_addr = m_awaddr; aw_got = 1; aw_cnt = 0;
            end else aw_cnt++;
         end
         if (m_wvalid && m_wready) begin
            if (w_exp_q.size() == 0) check("w_unexpected", 1, 0);
            else begin
               ew = w_exp_q.pop_front();
               check("w_data_strb_last", {m_wdata, m_wstrb, 7'd0, m_wlast}, {ew, 8'd1});
            end
            w_data = m_wdata; w_strb = m_wstrb; w_got = 1;
         end
         if (aw_got && w_got) begin
            cur = rd(aw_addr);
            for (int i = 0; i < 8; i++) if (w_strb[i]) cur[8*i +: 8] = w_data[8*i +: 8];
            mem[aw_addr] = cur;
            aw_got = 0; w_got = 0; b_pend = 1;
         end
         if (!aresetn) begin
            r_addr_q.delete(); r_len_q.delete(); r_id_q.delete();
            r_beat = 0; aw_got = 0; w_got = 0; b_pend = 0; ar_cnt = 0; aw_cnt = 0;
         end
      end
   end

   // Response monitor.
   initial begin
      logic [64:0] e;
      forever begin
         @(negedge aclk);
         #2;
         if (ifu_rvalid) begin
            if (ifu_exp_q.size() == 0) check("ifu_unexpected", {ifu_rlast, ifu_rdata}, 0);
            else begin
               e = ifu_exp_q.pop_front();
               check("ifu_beat", {ifu_rlast, ifu_rdata}, e);
            end
         end
         if (lsu_resp_valid) begin
            lsu_times.push_back(cyc);
            if (lsu_exp_q.size() == 0) check("lsu_unexpected", lsu_rdata, 0);
            else begin
               e = lsu_exp_q.pop_front();
               if (e[64]) check("lsu_wr_resp_with_b", m_bvalid, 1);
               else check("lsu_rd_data", lsu_rdata, e[63:0]);
            end
         end
      end
   end

   task automatic exp_ifu(input logic [31:0] a);
      logic [31:0] base;
      base = a & ~32'd31;
      ar_exp_q.push_back({base, 8'd3, 4'd0});
      for (int i = 0; i < 4; i++) ifu_exp_q.push_back({(i == 3), pat(base + 32'(8 * i))});
   endtask

   task automatic exp_lsu_rd(input logic [31:0] a, input logic [63:0] d);
      ar_exp_q.push_back({a, 8'd0, 4'd1});
      lsu_exp_q.push_back({1'b0, d});
   endtask

   task automatic run_reqs(input bit want_i, input logic [31:0] ia, input bit want_l,
                           input bit wen, input logic [31:0] la, input logic [63:0] wd,
                           input logic [7:0] ws, output bit first_lsu);
      bit got_i, got_l, first_set, overlap;
      int n;
      got_i = !want_i; got_l = !want_l; first_set = 0; first_lsu = 0; overlap = 0;
      ifu_req_valid = want_i; ifu_req_addr = ia;
      lsu_req_valid = want_l; lsu_req_wen = wen; lsu_req_addr = la;
      lsu_req_wdata = wd; lsu_req_wstrb = ws;
      n = 0;
      while (!(got_i && got_l) && n < 100) begin
         #1;
         if (ifu_req_ready && lsu_req_ready) overlap = 1;
         if (ifu_req_ready && !got_i) begin
            got_i = 1;
            if (!first_set) begin first_lsu = 0; first_set = 1; end
         end
         if (lsu_req_ready && !got_l) begin
            got_l = 1;
            if (!first_set) begin first_lsu = 1; first_set = 1; end
         end
         @(negedge aclk);
         if (got_i) ifu_req_valid = 0;
         if (got_l) lsu_req_valid = 0;
         n++;
      end
      ifu_req_valid = 0; lsu_req_valid = 0;
      check("req_granted", {got_i, got_l}, 2'b11);
      check("ready_overlap", overlap, 0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((ar_exp_q.size() + aw_exp_q.size() + w_exp_q.size() + ifu_exp_q.size() +
              lsu_exp_q.size()) != 0 && n < 300) begin
         @(negedge aclk);
         n++;
      end
      check("drain", ar_exp_q.size() + aw_exp_q.size() + w_exp_q.size() +
            ifu_exp_q.size() + lsu_exp_q.size(), 0);
      ar_exp_q.delete(); aw_exp_q.delete(); w_exp_q.delete();
      ifu_exp_q.delete(); lsu_exp_q.delete();
      repeat (2) @(negedge aclk);
   endtask

   initial begin
      bit first_lsu;
      int n, qs;
      aresetn = 0; ifu_req_valid = 0; ifu_req_addr = 0; lsu_req_valid = 0;
      lsu_req_wen = 0; lsu_req_addr = 0; lsu_req_wdata = 0; lsu_req_wstrb = 0;
      repeat (2) @(negedge aclk);
      #1;
      check("rst_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                           ifu_rvalid, lsu_resp_valid, ifu_req_ready, lsu_req_ready}, 0);
      check("rst_addr", {m_araddr, m_awaddr}, 0);
      check("rst_data", m_wdata, 0);
      check("rst_ids", {m_arid, m_awid, m_wlast}, 0);
      @(negedge aclk);
      aresetn = 1;

      // Both valid from reset: IFU first, then LSU read.
      exp_ifu(32'h8000_0014);
      exp_lsu_rd(32'h8000_0200, pat(32'h8000_0200));
      run_reqs(1, 32'h8000_0014, 1, 0, 32'h8000_0200, 0, 0, first_lsu);
      check("order_from_reset", first_lsu, 0);
      wait_idle();

      // LSU write with AW stalled: W handshakes first.
      aw_delay = 3;
      aw_exp_q.push_back(32'h8000_0100);
      w_exp_q.push_back({64'h0000_0000_DEAD_BEEF, 8'h0F});
      lsu_exp_q.push_back({1'b1, 64'd0});
      run_reqs(0, 0, 1, 1, 32'h8000_0100, 64'h0000_0000_DEAD_BEEF, 8'h0F, first_lsu);
      #1;
      check("wr_entry_aw_w", {m_awvalid, m_wvalid}, 2'b11);
      @(negedge aclk);
      #1;
      check("wr_w_drops_first", {m_awvalid, m_wvalid}, 2'b10);
      wait_idle();
      aw_delay = 0;

      exp_lsu_rd(32'h8000_0100, 64'h8000_0100_DEAD_BEEF);
      run_reqs(0, 0, 1, 0, 32'h8000_0100, 0, 0, first_lsu);
      wait_idle();

      // Stray LSU-id beat inside an IFU burst.
      stray_pend = 1;
      exp_ifu(32'h8000_0040);
      run_reqs(1, 32'h8000_0040, 0, 0, 0, 0, 0, first_lsu);
      wait_idle();
      check("stray_consumed", stray_pend, 0);

      // last_grant is IFU now: LSU wins.
      exp_lsu_rd(32'h8000_0008, pat(32'h8000_0008));
      exp_ifu(32'h8000_0080);
      run_reqs(1, 32'h8000_0080, 1, 0, 32'h8000_0008, 0, 0, first_lsu);
      check("order_after_ifu", first_lsu, 1);
      wait_idle();

      // Reset while beat 2 of a line fill is on the bus.
      exp_ifu(32'h8000_00C0);
      run_reqs(1, 32'h8000_00C0, 0, 0, 0, 0, 0, first_lsu);
      n = 0;
      while (ifu_exp_q.size() > 3 && n < 50) begin
         @(negedge aclk);
         #3;
         n++;
      end
      @(negedge aclk);
      aresetn = 0;
      @(negedge aclk);
      aresetn = 1;
      qs = ifu_exp_q.size();
      ifu_exp_q.delete();
      check("rst_mid_beats_left", qs, 2);
      #1;
      check("rst_mid_valids", {m_arvalid, m_awvalid, m_wvalid, ifu_rvalid,
                               lsu_resp_valid, m_rready}, 0);
      @(negedge aclk);
      exp_lsu_rd(32'h8000_0010, pat(32'h8000_0010));
      run_reqs(0, 0, 1, 0, 32'h8000_0010, 0, 0, first_lsu);
      wait_idle();

      // Back-to-back LSU reads: one response every 3 cycles.
      lsu_times.delete();
      for (int i = 0; i < 3; i++) exp_lsu_rd(32'h8000_0300 + 32'(8 * i),
                                             pat(32'h8000_0300 + 32'(8 * i)));
      for (int i = 0; i < 3; i++)
         run_reqs(0, 0, 1, 0, 32'h8000_0300 + 32'(8 * i), 0, 0, first_lsu);
      wait_idle();
      check("b2b_count", lsu_times.size(), 3);
      if (lsu_times.size() == 3) begin
         check("b2b_gap1", lsu_times[1] - lsu_times[0], 3);
         check("b2b_gap2", lsu_times[2] - lsu_times[1], 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
